ram_sync_param: RTL and testbench

//  Parametrised, clocked successor of the 8x8 byte RAM. WIDTH x DEPTH storage, single port.

---
 rtl/ram_sync_param.sv | 124 ++++++++++++
 tb/tb_ram_sync_param.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_sync_param.sv
// Single-port WIDTH x DEPTH synchronous RAM with a registered read port,
// per-read valid strobe, access-reject pulse and a hardware clear sequencer.

// One storage word: async reset, clear has priority over write.
module ram_sync_param_word #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             zero,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  // Word register update
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= '0;
    else if (zero) q <= '0;
    else if (we)   q <= d;
  end
endmodule

module ram_sync_param #(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              op,
  input  logic [ADDR_W-1:0] adr,
  input  logic [WIDTH-1:0]  inp,
  input  logic              clr,
  output logic [WIDTH-1:0]  outp,
  output logic              outp_valid,
  output logic              busy,
  output logic              err
);
  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                        state;
  logic [ADDR_W-1:0]             cnt;
  logic [DEPTH-1:0][WIDTH-1:0]   words;
  logic [DEPTH-1:0]              we;
  logic [DEPTH-1:0]              zero;
  logic                          in_range;
  logic                          accept;
  logic [WIDTH-1:0]              rd_word;

  // An access is taken only in IDLE and only when no clear is requested
  assign accept = (state == IDLE) && !clr && sel;

  // Addresses past DEPTH exist only when DEPTH is not a power of two
  if (DEPTH == (1 << ADDR_W)) begin : g_full
    assign in_range = 1'b1;
  end else begin : g_part
    assign in_range = (32'(adr) < DEPTH);
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    assign we[i]   = accept && op && in_range && (adr == ADDR_W'(i));
    assign zero[i] = (state == CLEAR) && (cnt == ADDR_W'(i));
    ram_sync_param_word #(.WIDTH(WIDTH)) u_word (
      .clk  (clk),
      .rst  (rst),
      .we   (we[i]),
      .zero (zero[i]),
      .d    (inp),
      .q    (words[i])
    );
  end

  // Read mux; out-of-range addresses read as zero
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < DEPTH; i++)
      if (adr == ADDR_W'(i)) rd_word = words[i];
  end

  // Control FSM with registered read data and status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      outp       <= '0;
      outp_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      outp_valid <= 1'b0;
      err        <= 1'b0;
      case (state)
        IDLE: begin
          if (clr) begin
            // clr wins; a coincident access is dropped and flagged
            state <= CLEAR;
            busy  <= 1'b1;
            cnt   <= '0;
            err   <= sel;
          end else if (sel) begin
            if (!in_range) err <= 1'b1;
            if (!op) begin
              outp       <= rd_word;
              outp_valid <= 1'b1;
            end
          end
        end
        CLEAR: begin
          // Accesses are rejected while busy; clr is ignored
          err <= sel;
          if (cnt == ADDR_W'(DEPTH - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_sync_param.sv
// Bench: two instances (8x8 and 16x6) driven cycle by cycle and compared
// against a behavioural model of the RAM and its clear sequence.
module tb_ram_sync_param;
  logic        clk = 1'b0;
  logic        rst;
  logic        sel [2];
  logic        op  [2];
  logic        clr [2];
  logic [2:0]  adr [2];
  logic [15:0] inp [2];

  logic [7:0]  outp_a;
  logic        vld_a, busy_a, err_a;
  logic [15:0] outp_b;
  logic        vld_b, busy_b, err_b;

  int checks = 0;
  int errors = 0;
  string phase = "init";

  always #5 clk = ~clk;

  ram_sync_param #(.WIDTH(8), .DEPTH(8)) u_a (
    .clk(clk), .rst(rst), .sel(sel[0]), .op(op[0]), .adr(adr[0]),
    .inp(inp[0][7:0]), .clr(clr[0]), .outp(outp_a), .outp_valid(vld_a),
    .busy(busy_a), .err(err_a));

  ram_sync_param #(.WIDTH(16), .DEPTH(6)) u_b (
    .clk(clk), .rst(rst), .sel(sel[1]), .op(op[1]), .adr(adr[1]),
    .inp(inp[1]), .clr(clr[1]), .outp(outp_b), .outp_valid(vld_b),
    .busy(busy_b), .err(err_b));

  // Reference model
  int          dep  [2] = '{8, 6};
  logic [15:0] mask [2] = '{16'h00FF, 16'hFFFF};
  logic [15:0] m_mem [2][8];
  logic [15:0] m_outp [2];
  bit          m_vld [2], m_busy [2], m_err [2];
  int          m_left [2];   // words still to be zeroed by the clear

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s/%s obs=%0h exp=%0h t=%0t", phase, tag, obs, exp, $time);
    end
  endtask

  task automatic mdl_rst();
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 8; a++) m_mem[k][a] = '0;
      m_outp[k] = '0; m_vld[k] = 0; m_busy[k] = 0; m_err[k] = 0; m_left[k] = 0;
    end
  endtask

  // One clock edge of behaviour for instance k
  task automatic mdl(input int k);
    int a;
    a = int'(adr[k]);
    m_vld[k] = 0;
    m_err[k] = 0;
    if (m_busy[k]) begin
      m_mem[k][dep[k] - m_left[k]] = '0;
      m_left[k]--;
      if (m_left[k] == 0) m_busy[k] = 0;
      m_err[k] = sel[k];
    end else if (clr[k]) begin
      m_busy[k] = 1;
      m_left[k] = dep[k];
      m_err[k]  = sel[k];
    end else if (sel[k]) begin
      if (a >= dep[k]) begin
        m_err[k] = 1;
        if (!op[k]) begin m_outp[k] = '0; m_vld[k] = 1; end
      end else if (op[k]) begin
        m_mem[k][a] = inp[k] & mask[k];
      end else begin
        m_outp[k] = m_mem[k][a];
        m_vld[k]  = 1;
      end
    end
  endtask

  task automatic cmp_all();
    chk("a.outp", {24'h0, outp_a}, {16'h0, m_outp[0]});
    chk("a.vld",  vld_a,  m_vld[0]);
    chk("a.busy", busy_a, m_busy[0]);
    chk("a.err",  err_a,  m_err[0]);
    chk("b.outp", {16'h0, outp_b}, {16'h0, m_outp[1]});
    chk("b.vld",  vld_b,  m_vld[1]);
    chk("b.busy", busy_b, m_busy[1]);
    chk("b.err",  err_b,  m_err[1]);
  endtask

  task automatic step();
    @(posedge clk);
    for (int k = 0; k < 2; k++) mdl(k);
    #1;
    cmp_all();
  endtask

  task automatic idle_all();
    for (int k = 0; k < 2; k++) begin
      sel[k] = 0; op[k] = 0; clr[k] = 0; adr[k] = '0; inp[k] = '0;
    end
  endtask

  task automatic acc(input int k, input bit s, input bit o, input int a,
                     input int d, input bit c);
    idle_all();
    sel[k] = s; op[k] = o; adr[k] = 3'(a); inp[k] = 16'(d); clr[k] = c;
    step();
  endtask

  // Async reset asserted between edges; outputs must clear without a clock
  task automatic async_reset();
    #3 rst = 1'b1;
    #1 mdl_rst();
    cmp_all();
    #2 rst = 1'b0;
  endtask

  initial begin
    idle_all();
    mdl_rst();
    rst = 1'b1;
    #7 cmp_all();
    rst = 1'b0;

    phase = "reset_reads";
    for (int a = 0; a < 8; a++) begin
      idle_all();
      sel[0] = 1; adr[0] = 3'(a); sel[1] = 1; adr[1] = 3'(a);
      step();
    end

    phase = "wr_rd";
    acc(0, 1, 1, 3, 'hA5, 0);
    acc(0, 1, 0, 3, 0, 0);
    chk("a5", {24'h0, outp_a}, 32'hA5);
    for (int i = 0; i < 5; i++) acc(0, 0, 0, 0, 0, 0);
    chk("a5.hold", {24'h0, outp_a}, 32'hA5);

    phase = "b2b";
    for (int i = 0; i < 8; i++) acc(0, 1, 1, i, 'h10 + i, 0);
    for (int i = 0; i < 8; i++) begin
      acc(0, 1, 0, i, 0, 0);
      chk("b2b.data", {24'h0, outp_a}, 32'h10 + i);
    end

    phase = "clear";
    acc(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      chk("busy.hi", busy_a, 1'b1);
      if (i == 2) acc(0, 1, 0, 4, 0, 1);
      else        acc(0, 0, 0, 0, 0, (i == 5));
    end
    chk("busy.lo", busy_a, 1'b0);
    chk("held", {24'h0, outp_a}, 32'h17);
    for (int i = 0; i < 8; i++) acc(0, 1, 0, i, 0, 0);

    phase = "boundary";
    for (int i = 0; i < 6; i++) acc(1, 1, 1, i, 'h1111 * (i + 1), 0);
    acc(1, 1, 1, 7, 'hDEAD, 0);
    acc(1, 1, 0, 7, 0, 0);
    chk("oor.vld", vld_b, 1'b1);
    acc(1, 1, 1, 5, 'hBEEF, 0);
    acc(1, 1, 0, 5, 0, 0);
    chk("beef", {16'h0, outp_b}, 32'hBEEF);
    for (int i = 0; i < 6; i++) acc(1, 1, 0, i, 0, 0);

    phase = "rst_mid_clear";
    acc(0, 0, 0, 0, 0, 1);
    acc(0, 0, 0, 0, 0, 0);
    acc(0, 0, 0, 0, 0, 0);
    async_reset();
    acc(0, 1, 1, 2, 'h3C, 0);
    acc(0, 1, 0, 2, 0, 0);
    chk("post_rst", {24'h0, outp_a}, 32'h3C);

    phase = "random";
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < 2; k++) begin
        sel[k] = ($urandom_range(0, 3) != 0);
        op[k]  = $urandom_range(0, 1);
        adr[k] = 3'($urandom);
        inp[k] = 16'($urandom);
        clr[k] = ($urandom_range(0, 29) == 0);
      end
      step();
    end

    phase = "final_reset";
    idle_all();
    async_reset();
    for (int a = 0; a < 8; a++) begin
      idle_all();
      sel[0] = 1; adr[0] = 3'(a); sel[1] = 1; adr[1] = 3'(a);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
